ddr5_req_queue: RTL and testbench

//  Host-side request queue that sits directly upstream of the DDR5 controller.
//  - Buffers tagged read/write requests in a FIFO.
//  - Issues them one at a time over the controller's cmd_valid/cmd_ready interface.
//  - Captures read data when the controller returns to idle, and returns it with its tag.
//  - Watchdog flags a controller that never completes a command.

---
 rtl/ddr5_req_queue_if.sv | 41 ++++
 rtl/ddr5_req_queue.sv | 162 ++++++++++++++++
 tb/tb_ddr5_req_queue.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr5_req_queue_if.sv
// Host request/response and memory-controller command bundle for ddr5_req_queue.
`timescale 1ns/1ps
interface ddr5_req_queue_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = 4
);
  logic                    host_valid;
  logic                    host_ready;
  logic                    host_read;
  logic [ADDR_WIDTH-1:0]   host_addr;
  logic [DATA_WIDTH-1:0]   host_wdata;
  logic [TAG_WIDTH-1:0]    host_tag;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [TAG_WIDTH-1:0]    rsp_tag;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    mc_cmd_valid;
  logic                    mc_cmd_read;
  logic [ADDR_WIDTH-1:0]   mc_addr;
  logic [DATA_WIDTH-1:0]   mc_wdata;
  logic                    mc_cmd_ready;
  logic [DATA_WIDTH-1:0]   mc_data_out;
  logic [$clog2(DEPTH):0]  level;
  logic                    err_timeout;

  modport master (
    output host_valid, host_read, host_addr, host_wdata, host_tag, rsp_ready,
           mc_cmd_ready, mc_data_out,
    input  host_ready, rsp_valid, rsp_tag, rsp_rdata, mc_cmd_valid, mc_cmd_read,
           mc_addr, mc_wdata, level, err_timeout
  );

  modport slave (
    input  host_valid, host_read, host_addr, host_wdata, host_tag, rsp_ready,
           mc_cmd_ready, mc_data_out,
    output host_ready, rsp_valid, rsp_tag, rsp_rdata, mc_cmd_valid, mc_cmd_read,
           mc_addr, mc_wdata, level, err_timeout
  );
endinterface

// File: rtl/ddr5_req_queue.sv
// DDR5 host request queue: FIFO of tagged requests issued one at a time to the
// memory controller; read data returned with its tag; watchdog on stuck commands.
//
// state | meaning
// IDLE  | nothing outstanding; loads FIFO head onto mc_* when level != 0
// ISSUE | mc_cmd_valid high until the controller accepts (FIFO pops)
// BUSY  | accepted; waiting for the controller to drop mc_cmd_ready
// WAIT  | controller working; waiting for mc_cmd_ready to return
// RESP  | read response held until the host takes it
`timescale 1ns/1ps
module ddr5_req_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8,
  parameter int TAG_WIDTH  = 4,
  parameter int TIMEOUT    = 255
) (
  input logic              clk_mem,
  input logic              rst,
  ddr5_req_queue_if.slave  bus
);
  localparam int         PTR_W    = $clog2(DEPTH);
  localparam int         LVL_W    = PTR_W + 1;
  localparam logic [8:0] WD_LIMIT = 9'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_BUSY, S_WAIT, S_RESP} state_t;

  typedef struct packed {
    logic                  rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  req_t                  mem [DEPTH];
  req_t                  head;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [LVL_W-1:0]      level_q;
  logic                  not_full, push, pop;

  state_t                state;
  logic                  cmd_valid_q, cmd_read_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic                  rsp_valid_q;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  err_q;
  logic [7:0]            wd_cnt;
  logic [8:0]            wd_next;
  logic                  wd_hit;

  assign not_full = (level_q != LVL_W'(DEPTH));
  assign push     = bus.host_valid && not_full;
  assign pop      = cmd_valid_q && bus.mc_cmd_ready;
  assign head     = mem[rd_ptr];
  assign wd_next  = {1'b0, wd_cnt} + 9'd1;
  assign wd_hit   = (wd_next == WD_LIMIT);

  // Storage needs no reset: occupancy is tracked by the pointers and level.
  always_ff @(posedge clk_mem) begin
    if (push) mem[wr_ptr] <= {bus.host_read, bus.host_addr, bus.host_wdata, bus.host_tag};
  end

  always_ff @(posedge clk_mem) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_mem) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tag_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (level_q != '0) begin
            cmd_read_q  <= head.rd;
            addr_q      <= head.addr;
            wdata_q     <= head.wdata;
            tag_q       <= head.tag;
            cmd_valid_q <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mc_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            wd_cnt      <= '0;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (wd_hit) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_next[7:0];
            if (!bus.mc_cmd_ready) state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Completion wins over a watchdog expiry landing on the same cycle.
          if (bus.mc_cmd_ready) begin
            if (cmd_read_q) begin
              rsp_valid_q <= 1'b1;
              rsp_tag_q   <= tag_q;
              rsp_rdata_q <= bus.mc_data_out;
              state       <= S_RESP;
            end else begin
              state <= S_IDLE;
            end
          end else if (wd_hit) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_next[7:0];
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.host_ready   = not_full;
  assign bus.level        = level_q;
  assign bus.mc_cmd_valid = cmd_valid_q;
  assign bus.mc_cmd_read  = cmd_read_q;
  assign bus.mc_addr      = addr_q;
  assign bus.mc_wdata     = wdata_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_tag      = rsp_tag_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_ddr5_req_queue.sv
// Bench for ddr5_req_queue: directed scenarios plus random traffic checked against
// an ordered-queue reference model and a behavioural memory-controller model.
`timescale 1ns/1ps
module tb_ddr5_req_queue;
  localparam int AW = 32, DW = 64, DEPTH = 8, TW = 4, TO = 20;

  logic clk_mem = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_mem = ~clk_mem;

  ddr5_req_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) bus ();

  ddr5_req_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TAG_WIDTH(TW),
                   .TIMEOUT(TO)) dut (
    .clk_mem (clk_mem),
    .rst     (rst),
    .bus     (bus)
  );

  typedef struct {logic rd; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [TW-1:0] tag;} req_t;
  typedef struct {logic [TW-1:0] tag; logic [DW-1:0] data;} rsp_t;

  req_t            pend_q[$];
  rsp_t            exp_rsp[$];
  logic [AW-1:0]   acc_addr_q[$];
  logic [DW-1:0]   mem_model [logic [AW-1:0]];
  req_t            r_m;
  rsp_t            e_m;

  int   n_checks = 0, n_pass = 0, n_acc = 0, n_rsp = 0, cyc = 0, last_acc_cyc = 0;
  logic last_acc_rd = 1'b0, err_prev = 1'b0;
  logic acc_flag = 1'b0;
  logic [DW-1:0] acc_val = '0, cur_val = '0;

  // controller / host knobs, changed only on the negative edge
  logic mc_hold = 1'b0, mc_hang = 1'b0, mc_rand = 1'b0, mc_dead = 1'b0;
  int   mc_lat = 3, busy_cnt = 0;
  logic rsp_rand = 1'b0, rsp_fix = 1'b1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  always @(posedge clk_mem) cyc++;

  // Reference model: FIFO contents, issue order, response order, watchdog timing.
  always @(negedge clk_mem) begin
    if (rst) begin
      pend_q.delete();
      exp_rsp.delete();
      acc_flag = 1'b0;
      err_prev = 1'b0;
    end else begin
      check_val("level", bus.level, pend_q.size());
      check_val("host_ready", bus.host_ready, pend_q.size() != DEPTH);
      acc_flag = bus.mc_cmd_valid && bus.mc_cmd_ready;
      if (acc_flag) begin
        check_val("acc_expected", pend_q.size() != 0, 1);
        if (pend_q.size() != 0) begin
          r_m = pend_q.pop_front();
          check_val("acc_read", bus.mc_cmd_read, r_m.rd);
          check_val("acc_addr", bus.mc_addr, r_m.addr);
          if (!r_m.rd) begin
            check_val("acc_wdata", bus.mc_wdata, r_m.wdata);
            mem_model[r_m.addr] = r_m.wdata;
          end else begin
            acc_val = mem_model.exists(r_m.addr) ? mem_model[r_m.addr] : {r_m.addr, ~r_m.addr};
            exp_rsp.push_back('{r_m.tag, acc_val});
          end
          last_acc_rd = r_m.rd;
        end
        acc_addr_q.push_back(bus.mc_addr);
        n_acc++;
        last_acc_cyc = cyc + 1;
      end
      if (bus.host_valid && bus.host_ready)
        pend_q.push_back('{bus.host_read, bus.host_addr, bus.host_wdata, bus.host_tag});
      if (bus.rsp_valid && bus.rsp_ready) begin
        n_rsp++;
        check_val("rsp_expected", exp_rsp.size() != 0, 1);
        if (exp_rsp.size() != 0) begin
          e_m = exp_rsp.pop_front();
          check_val("rsp_tag", bus.rsp_tag, e_m.tag);
          check_val("rsp_rdata", bus.rsp_rdata, e_m.data);
        end
      end
      if (bus.err_timeout && !err_prev) begin
        check_val("timeout_cycles", cyc - last_acc_cyc, TO);
        if (last_acc_rd && exp_rsp.size() != 0) exp_rsp.delete(exp_rsp.size() - 1);
      end
      err_prev = bus.err_timeout;
    end
  end

  // Memory controller model: drops ready after accept, returns ready (with read data) later.
  always @(posedge clk_mem) begin
    #1;
    if (acc_flag) begin
      busy_cnt = mc_rand ? int'($urandom_range(1, 4)) : mc_lat;
      mc_dead  = mc_hang;
      cur_val  = acc_val;
      bus.mc_cmd_ready = 1'b0;
      bus.mc_data_out  = {$urandom, $urandom};
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        bus.mc_cmd_ready = !(mc_dead && mc_hang);
        bus.mc_data_out  = cur_val;
      end else begin
        bus.mc_data_out = {$urandom, $urandom};
      end
    end else begin
      bus.mc_cmd_ready = !mc_hold && !(mc_dead && mc_hang);
      bus.mc_data_out  = {$urandom, $urandom};
    end
  end

  always @(posedge clk_mem) begin
    #1;
    bus.rsp_ready = rsp_rand ? ($urandom_range(0, 3) != 0) : rsp_fix;
  end

  task automatic sync();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic push_req(input logic rd, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [TW-1:0] t);
    int i = 0;
    bus.host_valid = 1'b1;
    bus.host_read  = rd;
    bus.host_addr  = a;
    bus.host_wdata = d;
    bus.host_tag   = t;
    do begin
      @(negedge clk_mem);
      i++;
    end while (!bus.host_ready && i < 200);
    if (!bus.host_ready) check_val("push_wait", bus.host_ready, 1);
    sync();
    bus.host_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int quiet = 0;
    int i = 0;
    while (quiet < 4 && i < 3000) begin
      @(negedge clk_mem);
      i++;
      if (pend_q.size() == 0 && exp_rsp.size() == 0 && busy_cnt == 0 &&
          !bus.mc_cmd_valid && !bus.rsp_valid) quiet++;
      else quiet = 0;
    end
    check_val(tag, quiet >= 4, 1);
    sync();
  endtask

  initial begin
    int rsp0, acc0, nrd, base, i;
    logic rd;
    bus.host_valid = 1'b0;
    bus.host_read  = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.host_tag   = '0;
    repeat (3) @(posedge clk_mem);
    #1 rst = 1'b0;
    @(negedge clk_mem);
    check_val("rst_host_ready", bus.host_ready, 1);
    check_val("rst_level", bus.level, 0);
    check_val("rst_cmd_valid", bus.mc_cmd_valid, 0);
    check_val("rst_rsp_valid", bus.rsp_valid, 0);
    check_val("rst_err", bus.err_timeout, 0);
    sync();

    // single write
    acc0 = n_acc; rsp0 = n_rsp;
    push_req(1'b0, 32'h100, 64'hDEADBEEF12345678, 4'h1);
    @(negedge clk_mem);
    check_val("t1_level1", bus.level, 1);
    drain("t1_drain");
    check_val("t1_acc_count", n_acc - acc0, 1);
    check_val("t1_rsp_count", n_rsp - rsp0, 0);
    check_val("t1_acc_addr", acc_addr_q[acc_addr_q.size()-1], 32'h100);
    check_val("t1_level0", bus.level, 0);

    // read with response backpressure
    @(negedge clk_mem); rsp_fix = 1'b0;
    sync();
    rsp0 = n_rsp;
    push_req(1'b1, 32'h100, 64'h0, 4'h5);
    i = 0;
    while (!bus.rsp_valid && i < 100) begin @(negedge clk_mem); i++; end
    check_val("t2_rsp_valid", bus.rsp_valid, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_mem);
      check_val("t2_hold_valid", bus.rsp_valid, 1);
      check_val("t2_hold_tag", bus.rsp_tag, 4'h5);
      check_val("t2_hold_data", bus.rsp_rdata, 64'hDEADBEEF12345678);
    end
    rsp_fix = 1'b1;
    drain("t2_drain");
    check_val("t2_rsp_count", n_rsp - rsp0, 1);

    // fill to full with the controller stalled
    @(negedge clk_mem); mc_hold = 1'b1;
    sync();
    acc0 = n_acc; base = acc_addr_q.size();
    for (int k = 0; k < 8; k++) push_req(1'b0, 32'h200 + 32'(8 * k), {$urandom, $urandom}, 4'(k));
    bus.host_valid = 1'b1;
    bus.host_addr  = 32'h2FF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_mem);
      check_val("t3_full_ready", bus.host_ready, 0);
      check_val("t3_full_level", bus.level, 8);
    end
    sync();
    bus.host_valid = 1'b0;
    @(negedge clk_mem); mc_hold = 1'b0;
    drain("t3_drain");
    check_val("t3_acc_count", n_acc - acc0, 8);
    for (int k = 0; k < 8; k++)
      check_val("t3_order", acc_addr_q[base + k], 32'h200 + 32'(8 * k));

    // simultaneous push and pop at level 3, then wraparound traffic
    @(negedge clk_mem); mc_hold = 1'b1;
    sync();
    for (int k = 0; k < 3; k++) push_req(1'b0, 32'h300 + 32'(8 * k), {$urandom, $urandom}, 4'(k));
    @(negedge clk_mem);
    check_val("t4_level3", bus.level, 3);
    mc_hold = 1'b0;
    sync();
    push_req(1'b0, 32'h318, {$urandom, $urandom}, 4'h3);
    @(negedge clk_mem);
    check_val("t4_pushpop_level", bus.level, 3);
    sync();
    for (int k = 0; k < 12; k++) push_req(1'b0, 32'h400 + 32'(8 * k), {$urandom, $urandom}, 4'(k));
    drain("t4_drain");

    // random traffic
    @(negedge clk_mem); mc_rand = 1'b1; rsp_rand = 1'b1;
    sync();
    rsp0 = n_rsp; nrd = 0;
    for (int k = 0; k < 60; k++) begin
      rd = 1'($urandom_range(0, 1));
      if (rd) nrd++;
      push_req(rd, 32'h100 + 32'(8 * $urandom_range(0, 7)), {$urandom, $urandom},
               4'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 2)) sync();
    end
    drain("rand_drain");
    check_val("rand_rsp_count", n_rsp - rsp0, nrd);
    check_val("rand_err_clear", bus.err_timeout, 0);
    @(negedge clk_mem); mc_rand = 1'b0; rsp_rand = 1'b0; rsp_fix = 1'b1;

    // watchdog: controller never completes
    mc_hang = 1'b1;
    sync();
    push_req(1'b1, 32'h100, 64'h0, 4'h9);
    i = 0;
    while (!bus.err_timeout && i < 200) begin @(negedge clk_mem); i++; end
    check_val("t5_err", bus.err_timeout, 1);
    @(negedge clk_mem);
    check_val("t5_idle_cmd", bus.mc_cmd_valid, 0);
    check_val("t5_no_rsp", bus.rsp_valid, 0);
    check_val("t5_level", bus.level, 0);
    mc_hang = 1'b0;
    sync();
    rsp0 = n_rsp;
    push_req(1'b0, 32'h140, 64'h0123456789ABCDEF, 4'h2);
    push_req(1'b1, 32'h140, 64'h0, 4'h3);
    drain("t5_drain");
    check_val("t5_rsp_count", n_rsp - rsp0, 1);
    check_val("t5_err_sticky", bus.err_timeout, 1);

    // reset while a command is in WAIT with 4 queued
    @(negedge clk_mem); mc_lat = 15; mc_hold = 1'b1;
    sync();
    for (int k = 0; k < 5; k++) push_req(1'b0, 32'h500 + 32'(8 * k), {$urandom, $urandom}, 4'(k));
    @(negedge clk_mem); mc_hold = 1'b0;
    acc0 = n_acc; i = 0;
    while (n_acc == acc0 && i < 100) begin @(negedge clk_mem); i++; end
    check_val("t6_acc", n_acc - acc0, 1);
    repeat (3) @(negedge clk_mem);
    check_val("t6_level4", bus.level, 4);
    sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk_mem);
    check_val("t6_level", bus.level, 0);
    check_val("t6_host_ready", bus.host_ready, 1);
    check_val("t6_cmd_valid", bus.mc_cmd_valid, 0);
    check_val("t6_cmd_read", bus.mc_cmd_read, 0);
    check_val("t6_addr", bus.mc_addr, 0);
    check_val("t6_wdata", bus.mc_wdata, 0);
    check_val("t6_rsp_valid", bus.rsp_valid, 0);
    check_val("t6_rsp_tag", bus.rsp_tag, 0);
    check_val("t6_rsp_rdata", bus.rsp_rdata, 0);
    check_val("t6_err", bus.err_timeout, 0);
    mc_lat = 3;
    sync();
    rsp0 = n_rsp;
    push_req(1'b1, 32'h200, 64'h0, 4'hC);
    drain("t6_drain");
    check_val("t6_rsp_count", n_rsp - rsp0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "stopping");
  end
endmodule
